pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the write-enable and flush inputs of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It resolves three hazard types:
- load-use hazards (bubble insertion),
- taken branches resolved in MEM (three-stage flush),
- multi-cycle data-memory accesses (full freeze, with timeout).
It also keeps stall and flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, MEM-stage
// branch flushes, and freezes on multi-cycle data-memory accesses with a timeout.
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ID_rs1,
   input  logic [4:0]       ID_rs2,
   input  logic             ID_uses_rs2,
   input  logic             IE_MemRead,
   input  logic [4:0]       IE_RD,
   input  logic             EM_Branch,
   input  logic             EM_Zero,
   input  logic             EM_addermuxselect,
   input  logic             EM_MemRead,
   input  logic             EM_MemWrite,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             ex_mem_flush,
   output logic             mem_wb_flush,
   output logic             pc_src,
   output logic             mem_fault,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic {RUN, MEM_WAIT} state_e;

   localparam int              WC_W      = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0] TIMEOUT_C = WC_W'(MEM_TIMEOUT);

   state_e           state_q, state_d;
   logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic             mem_fault_q, mem_fault_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   logic mem_acc, taken, load_use, in_wait, freeze, timeout;

   always_comb begin
      mem_acc  = EM_MemRead | EM_MemWrite;
      taken    = EM_Branch & (EM_Zero ^ EM_addermuxselect);
      load_use = IE_MemRead & (IE_RD != 5'd0) &
                 ((IE_RD == ID_rs1) | (ID_uses_rs2 & (IE_RD == ID_rs2)));
      in_wait  = (state_q == MEM_WAIT);
      freeze   = (!in_wait & mem_acc & !dmem_ready) |
                 (in_wait & !dmem_ready & (wait_cnt_q < TIMEOUT_C));
      timeout  = in_wait & !dmem_ready & (wait_cnt_q >= TIMEOUT_C);
   end

   // NOTE: every output and next-state value gets a default first so no path leaves a latch.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_fault_d   = mem_fault_q;
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      dmem_req      = mem_acc | in_wait;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_flush   = 1'b0;
      ex_mem_write  = 1'b1;
      ex_mem_flush  = 1'b0;
      mem_wb_flush  = 1'b0;
      pc_src        = 1'b0;

      case (state_q)
         RUN: begin
            if (mem_acc && !dmem_ready) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WC_W'(1);
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (timeout) begin
               state_d     = RUN;
               wait_cnt_d  = '0;
               mem_fault_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WC_W'(1);
            end
         end
         default: state_d = RUN;
      endcase

      // A taken branch squashes the load-using instruction, so it wins over load-use.
      if (freeze) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (taken) begin
         pc_src       = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (load_use) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_flush  = 1'b1;
      end

      // The timed-out access is discarded rather than written back.
      if (timeout) mem_wb_flush = 1'b1;

      if (freeze || (load_use && !taken)) stall_count_d = stall_count_q + CNT_W'(1);
      if (taken && !freeze)               flush_count_d = flush_count_q + CNT_W'(1);
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         mem_fault_q   <= 1'b0;
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_fault_q   <= mem_fault_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign mem_fault   = mem_fault_q;
   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares every presented cycle.
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 4;

   // {dmem_req,pc_write,if_id_write,if_id_flush,id_ex_write,id_ex_flush,ex_mem_write,ex_mem_flush,mem_wb_flush,pc_src}
   localparam logic [9:0] RUN_V   = 10'b0_1_1_0_1_0_1_0_0_0;
   localparam logic [9:0] LU_V    = 10'b0_0_0_0_1_1_1_0_0_0;
   localparam logic [9:0] BR_V    = 10'b0_1_1_1_1_1_1_1_0_1;
   localparam logic [9:0] BRM_V   = 10'b1_1_1_1_1_1_1_1_0_1;
   localparam logic [9:0] FRZ_V   = 10'b1_0_0_0_0_0_0_0_1_0;
   localparam logic [9:0] MEMOK_V = 10'b1_1_1_0_1_0_1_0_0_0;
   localparam logic [9:0] TO_V    = 10'b1_1_1_0_1_0_1_0_1_0;

   typedef struct {
      logic [9:0]       ctl;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
      logic             flt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] ID_rs1, ID_rs2, IE_RD;
   logic ID_uses_rs2, IE_MemRead, EM_Branch, EM_Zero, EM_addermuxselect;
   logic EM_MemRead, EM_MemWrite, dmem_ready;
   logic dmem_req, pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
   logic ex_mem_write, ex_mem_flush, mem_wb_flush, pc_src, mem_fault;
   logic [CNT_W-1:0] stall_count, flush_count;

   exp_t exp_q[$];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs2(ID_uses_rs2),
      .IE_MemRead(IE_MemRead), .IE_RD(IE_RD),
      .EM_Branch(EM_Branch), .EM_Zero(EM_Zero), .EM_addermuxselect(EM_addermuxselect),
      .EM_MemRead(EM_MemRead), .EM_MemWrite(EM_MemWrite), .dmem_ready(dmem_ready),
      .dmem_req(dmem_req), .pc_write(pc_write), .if_id_write(if_id_write),
      .if_id_flush(if_id_flush), .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
      .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
      .pc_src(pc_src), .mem_fault(mem_fault),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge and queue the expected response.
   task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                       input logic ie_mr, input logic [4:0] rd,
                       input logic [2:0] br_z_a, input logic [2:0] mr_mw_rdy, input logic rst,
                       input logic [9:0] ctl, input int sc, input int fc, input logic flt);
      exp_t e;
      @(posedge clk);
      #1;
      reset             = rst;
      ID_rs1            = rs1;
      ID_rs2            = rs2;
      ID_uses_rs2       = u2;
      IE_MemRead        = ie_mr;
      IE_RD             = rd;
      {EM_Branch, EM_Zero, EM_addermuxselect} = br_z_a;
      {EM_MemRead, EM_MemWrite, dmem_ready}   = mr_mw_rdy;
      e.ctl = ctl;
      e.sc  = CNT_W'(sc);
      e.fc  = CNT_W'(fc);
      e.flt = flt;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ctl", 32'({dmem_req, pc_write, if_id_write, if_id_flush, id_ex_write,
                               id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_flush, pc_src}),
                  32'(e.ctl));
            check("stall_count", 32'(stall_count), 32'(e.sc));
            check("flush_count", 32'(flush_count), 32'(e.fc));
            check("mem_fault",   32'(mem_fault),   32'(e.flt));
         end
      end
   end

   initial begin : driver
      reset = 1'b1;
      {ID_rs1, ID_rs2, ID_uses_rs2, IE_MemRead, IE_RD} = '0;
      {EM_Branch, EM_Zero, EM_addermuxselect, EM_MemRead, EM_MemWrite, dmem_ready} = '0;
      repeat (2) @(posedge clk);

      // reset state, load-use via rs1/rs2, rd=0 exemption
      step(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, RUN_V, 0, 0, 0);
      step(5, 0, 0, 1, 5, 3'b000, 3'b000, 0, LU_V,  0, 0, 0);
      step(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, RUN_V, 1, 0, 0);
      step(0, 0, 0, 1, 0, 3'b000, 3'b000, 0, RUN_V, 1, 0, 0);
      step(3, 7, 1, 1, 7, 3'b000, 3'b000, 0, LU_V,  1, 0, 0);
      step(3, 7, 0, 1, 7, 3'b000, 3'b000, 0, RUN_V, 2, 0, 0);
      // taken bne overriding load-use, not-taken bne, taken beq
      step(5, 0, 0, 1, 5, 3'b101, 3'b000, 0, BR_V,  2, 0, 0);
      step(0, 0, 0, 0, 0, 3'b111, 3'b000, 0, RUN_V, 2, 1, 0);
      step(0, 0, 0, 0, 0, 3'b110, 3'b000, 0, BR_V,  2, 1, 0);
      step(0, 0, 0, 0, 0, 3'b010, 3'b000, 0, RUN_V, 2, 2, 0);
      // zero-wait access, then 3 wait cycles
      step(0, 0, 0, 0, 0, 3'b000, 3'b101, 0, MEMOK_V, 2, 2, 0);
      step(0, 0, 0, 0, 0, 3'b000, 3'b100, 0, FRZ_V,   2, 2, 0);
      step(0, 0, 0, 0, 0, 3'b000, 3'b100, 0, FRZ_V,   3, 2, 0);
      step(0, 0, 0, 0, 0, 3'b000, 3'b100, 0, FRZ_V,   4, 2, 0);
      step(0, 0, 0, 0, 0, 3'b000, 3'b101, 0, MEMOK_V, 5, 2, 0);
      step(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, RUN_V,   5, 2, 0);
      // branch held during a store freeze applies on the release cycle
      step(0, 0, 0, 0, 0, 3'b101, 3'b010, 0, FRZ_V,   5, 2, 0);
      step(0, 0, 0, 0, 0, 3'b101, 3'b011, 0, BRM_V,   6, 2, 0);
      step(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, RUN_V,   6, 3, 0);
      // timeout: 16 frozen cycles, release on the 17th, sticky fault
      for (int k = 0; k < 16; k++)
         step(0, 0, 0, 0, 0, 3'b000, 3'b100, 0, FRZ_V, (6 + k) % 16, 3, 0);
      step(0, 0, 0, 0, 0, 3'b000, 3'b100, 0, TO_V,  6, 3, 0);
      step(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, RUN_V, 6, 3, 1);
      step(5, 0, 0, 1, 5, 3'b000, 3'b000, 0, LU_V,  6, 3, 1);
      step(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, RUN_V, 7, 3, 1);
      // reset asserted asynchronously in the second MEM_WAIT cycle
      step(0, 0, 0, 0, 0, 3'b000, 3'b100, 0, FRZ_V, 7, 3, 1);
      step(0, 0, 0, 0, 0, 3'b000, 3'b100, 0, FRZ_V, 8, 3, 1);
      step(0, 0, 0, 0, 0, 3'b000, 3'b000, 1, RUN_V, 0, 0, 0);
      step(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, RUN_V, 0, 0, 0);
      // 17 load-use stalls wrap a 4-bit counter to 1
      for (int i = 0; i < 17; i++)
         step(9, 0, 0, 1, 9, 3'b000, 3'b000, 0, LU_V, i % 16, 0, 0);
      step(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, RUN_V, 1, 0, 0);

      repeat (2) @(posedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
